mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-side stage upstream of the LC-3 datapath's MDR. It turns ISDU read/write requests into
//  timed strobes for an asynchronous SRAM (addressed by MAR, written with MDR). It returns read
//  data on MDR_in and signals completion to the ISDU with R.
//  With MIO enabled, the datapath loads MDR from MDR_in; the ISDU waits in a memory state until R.
// PARAMETERS
//  WAIT_STATES  2    SRAM access cycles held with strobes active; legal 1..15
//  ADDR_W       20   SRAM address width; MAR zero-extended into it
// PORTS
//  Clk            in   1       system clock, all state on rising edge
//  Reset          in   1       asynchronous, active-low reset
//  MEM_REQ        in   1       ISDU request; sampled only in IDLE
//  MEM_WE         in   1       1=write, 0=read; sampled with MEM_REQ
//  MAR            in   16      word address from datapath MAR
//  MDR            in   16      write data from datapath MDR
//  SW             in   16      board switches (MMIO read source)
//  R              out  1       access complete, one-cycle pulse to ISDU
//  MDR_in         out  16      read data to datapath MDR mux
//  BUSY           out  1       1 in any state other than IDLE
//  ADDR           out  ADDR_W  SRAM address
//  Data_to_SRAM   out  16      SRAM write data
//  Data_from_SRAM in   16      SRAM read data
//  CE_N,UB_N,LB_N out  1       SRAM chip/byte enables, active-low
//  OE_N,WE_N      out  1       SRAM output/write enables, active-low
//  HEX_OUT        out  16      MMIO display register
// BEHAVIOUR
//  Reset (Reset=0, takes effect immediately, without waiting for Clk):
//   - State=IDLE; R=0; BUSY=0; MDR_in=0; HEX_OUT=0; ADDR=0; Data_to_SRAM=0.
//   - CE_N=UB_N=LB_N=OE_N=WE_N=1.
//  FSM states: IDLE -> SETUP -> ACCESS(xWAIT_STATES) -> DONE -> IDLE.
//  - IDLE: if MEM_REQ=1 at edge k, latch MAR->ADDR, MEM_WE->op, MDR->Data_to_SRAM; go to SETUP.
//  - SETUP (cycle k+1): CE_N=UB_N=LB_N=0; OE_N=WE_N=1. Lets the address settle.
//  - ACCESS (cycles k+2..k+1+W): read: OE_N=0; write: WE_N=0.
//    A 4-bit counter counts W-1 down to 0. On the last ACCESS edge, a read latches
//    Data_from_SRAM into MDR_in.
//  - DONE (cycle k+2+W): all strobes=1; R=1 for exactly this cycle; next state IDLE unconditionally.
//  Latency: R high W+2 cycles after the request edge. Default W=2 gives R in cycle k+4.
//  - MDR_in holds its value until the next read completes. Writes never change MDR_in.
//  - MAR, MDR and MEM_WE are ignored outside IDLE. Changing them mid-access has no effect.
//  - MEM_REQ still high in the IDLE cycle after DONE starts a new access: back-to-back
//    accesses with a 1-cycle IDLE gap. The ISDU drops MEM_REQ on R.
//  - Address, data and byte enables stay stable from SETUP through DONE.
//  - WE_N rises at the DONE edge, while address and data are still held (write hold time).
//  - Reset asserted mid-access aborts immediately:
//    - No R pulse.
//    - MDR_in keeps its reset value 0.
//    - A partially completed SRAM write is undefined by design.
//  - WAIT_STATES=1: ACCESS lasts one cycle; the counter is unused.
// CONFIGURATION
//  MEM_MMIO_EN defined:
//   - Latched address 16'hFFFF is memory-mapped I/O. CE_N stays 1 for the whole access.
//   - Read returns SW into MDR_in; write loads MDR into HEX_OUT at the last ACCESS edge.
//   - Timing and R pulse are identical to SRAM accesses.
//  MEM_MMIO_EN undefined:
//   - 16'hFFFF is ordinary SRAM; SW is unused; HEX_OUT is held at 0.
// TESTING
//  1 Reset=0 mid-ACCESS of a read -> strobes all 1 immediately, R never pulses, MDR_in=0, BUSY=0.
//  2 W=2, read MAR=16'h0010, SRAM returns 16'hBEEF -> OE_N=0 two cycles, R=1 in cycle k+4,
//    MDR_in=16'hBEEF.
//  3 Write MAR=16'h0020, MDR=16'h1234 -> WE_N=0 exactly W cycles, ADDR=20'h00020 held through DONE,
//    later read of 16'h0020 returns 16'h1234.
//  4 MEM_REQ held high over two reads; MAR changed to 16'h0030 during the first access ->
//    first access uses the old address; second starts one IDLE cycle after R and uses 16'h0030.
//  5 MEM_MMIO_EN: write 16'h00A5 to 16'hFFFF -> HEX_OUT=16'h00A5, CE_N stays 1.
//    Read 16'hFFFF with SW=16'h0F0F -> MDR_in=16'h0F0F.
//  6 MEM_MMIO_EN undefined: same write to 16'hFFFF -> SRAM WE_N pulses, HEX_OUT stays 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Sequences ISDU read/write requests into asynchronous SRAM strobes and returns read data on MDR_in.
// Optional MEM_MMIO_EN maps latched address 16'hFFFF to SW (read) and HEX_OUT (write).
//
// state  | meaning
// IDLE   | waiting for MEM_REQ; latches MAR/MDR/MEM_WE on request
// SETUP  | chip and byte enables low, address settling
// ACCESS | OE_N or WE_N low for WAIT_STATES cycles
// DONE   | OE_N/WE_N high with address/data still held; R pulses
module mem_access_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MEM_REQ,
    input  logic              MEM_WE,
    input  logic [15:0]       MAR,
    input  logic [15:0]       MDR,
    input  logic [15:0]       SW,
    output logic              R,
    output logic [15:0]       MDR_in,
    output logic              BUSY,
    output logic [ADDR_W-1:0] ADDR,
    output logic [15:0]       Data_to_SRAM,
    input  logic [15:0]       Data_from_SRAM,
    output logic              CE_N,
    output logic              UB_N,
    output logic              LB_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic [15:0]       HEX_OUT
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       op_we;
    logic       last_access;
    logic       mmio;

    assign last_access = (state == ACCESS) && (cnt == 4'd0);

`ifdef MEM_MMIO_EN
    assign mmio = (ADDR[15:0] == 16'hFFFF);
`else
    logic unused_sw;
    assign mmio      = 1'b0;
    assign unused_sw = ^SW;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (MEM_REQ) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Enables stay low through DONE so WE_N rises while address and data are still driven.
    always_comb begin
        CE_N = 1'b1;
        UB_N = 1'b1;
        LB_N = 1'b1;
        OE_N = 1'b1;
        WE_N = 1'b1;
        R    = 1'b0;
        BUSY = (state != IDLE);
        case (state)
            SETUP, DONE: begin
                CE_N = mmio;
                UB_N = 1'b0;
                LB_N = 1'b0;
                R    = (state == DONE);
            end
            ACCESS: begin
                CE_N = mmio;
                UB_N = 1'b0;
                LB_N = 1'b0;
                OE_N = op_we;
                WE_N = ~op_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ADDR         <= '0;
            Data_to_SRAM <= 16'h0000;
            op_we        <= 1'b0;
            cnt          <= 4'd0;
            MDR_in       <= 16'h0000;
        end else begin
            if (state == IDLE && MEM_REQ) begin
                ADDR         <= ADDR_W'(MAR);
                Data_to_SRAM <= MDR;
                op_we        <= MEM_WE;
            end
            if (state == SETUP)
                cnt <= CNT_INIT;
            else if (state == ACCESS && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (last_access && !op_we)
                MDR_in <= mmio ? SW : Data_from_SRAM;
        end
    end

`ifdef MEM_MMIO_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            HEX_OUT <= 16'h0000;
        else if (last_access && op_we && mmio)
            HEX_OUT <= Data_to_SRAM;
    end
`else
    assign HEX_OUT = 16'h0000;
`endif

endmodule
